// File: rtl/bit_accuracy_sequencer_if.sv
// Purpose : bundles the control, stimulus and result signals of bit_accuracy_sequencer.
// Ports   : start/test_count/seed in, stim_o out, dut_o/ref_o in, busy/done/counters/first_fail_* out.
// Modports: master = the sequencer itself; slave = the test wrapper driving it.
interface bit_accuracy_sequencer_if #(
    parameter int IN_W  = 1894,
    parameter int CNT_W = 32
);
    logic             start;
    logic [CNT_W-1:0] test_count;
    logic [63:0]      seed;
    logic [IN_W-1:0]  stim_o;
    logic             dut_o;
    logic             ref_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic             first_fail_valid;
    logic [CNT_W-1:0] first_fail_idx;

    modport master (
        input  start, test_count, seed, dut_o, ref_o,
        output stim_o, busy, done, pass_count, fail_count, first_fail_valid, first_fail_idx
    );

    modport slave (
        output start, test_count, seed, dut_o, ref_o,
        input  stim_o, busy, done, pass_count, fail_count, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/bit_accuracy_sequencer.sv
// Purpose : applies LFSR stimulus to one generated output-bit circuit and scores dut_o against ref_o.
// Ports   : clk, rst (sync, active-high); bus (master modport) carries start/config, stim_o, dut_o/ref_o, status, counters.
// Option  : STOP_ON_FAIL_EN - first mismatch stops issuing vectors; in-flight vectors are still scored.
// Timing  : 1 vector/clock in RUN; results arrive LAT cycles after presentation; start ignored while busy.
module bit_accuracy_sequencer #(
    parameter int IN_W  = 1894,
    parameter int LAT   = 1,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    bit_accuracy_sequencer_if.master  bus
);
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [63:0]      r_lfsr;
    logic [IN_W-1:0]  r_stim;
    logic [CNT_W-1:0] r_tc, r_issue_idx, r_check_idx;
    logic [CNT_W-1:0] r_pass, r_fail, r_ff_idx;
    logic             r_ff_vld;
    logic [LAT-1:0]   r_tag;

    logic             w_busy, w_done;
    logic             w_start_acc, w_issue, w_last, w_adv, w_sample, w_mis;
    logic [63:0]      w_seed, w_lfsr_nxt;
    logic [LAT:0]     w_tag_ext;
    logic [LAT-1:0]   w_tag_nxt;

    // Chunk j of the stimulus is lfsr rotated left by j mod 64, so bit i
    // comes from lfsr[(i mod 64) - j] with the subtraction wrapping mod 64.
    function automatic logic [IN_W-1:0] f_stim(input logic [63:0] l);
        logic [IN_W-1:0] v;
        logic [5:0]      sh;
        v = '0;
        for (int i = 0; i < IN_W; i++) begin
            sh   = 6'((i % 64) - (i / 64));
            v[i] = l[sh];
        end
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_start_acc = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_seed      = (bus.seed == 64'h0) ? 64'h1 : bus.seed;
    assign w_lfsr_nxt  = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? TAPS : 64'h0);
    assign w_issue     = (r_state == S_RUN);
    assign w_last      = w_issue && (r_issue_idx == r_tc - CNT_W'(1));
    assign w_sample    = r_tag[LAT-1];
    assign w_mis       = w_sample && (bus.dut_o != bus.ref_o);
    // Shift the issue flag into the tag pipe; the concat-then-slice form stays legal for LAT == 1.
    assign w_tag_ext   = {r_tag, w_issue};
    assign w_tag_nxt   = w_tag_ext[LAT-1:0];

`ifdef STOP_ON_FAIL_EN
    // The vector on stim_o in the mismatch cycle is the last one issued; stim_o freezes on it.
    assign w_adv = w_issue && !w_last && !w_mis;
`else
    assign w_adv = w_issue && !w_last;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_acc) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = (r_tc == '0) ? S_DONE : S_RUN;
`ifdef STOP_ON_FAIL_EN
            S_RUN:   if (w_last || w_mis) w_state_nxt = S_DRAIN;
`else
            S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
`endif
            // Leave once the tag about to be sampled is the final one in the pipe.
            S_DRAIN: if (w_tag_nxt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (w_start_acc) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_LOAD, S_RUN, S_DRAIN: w_busy = 1'b1;
            S_DONE:                 w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: LFSR, stimulus, tag pipe and scoring counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= 64'h1;
            r_stim      <= '0;
            r_tc        <= '0;
            r_issue_idx <= '0;
            r_check_idx <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_ff_vld    <= 1'b0;
            r_ff_idx    <= '0;
            r_tag       <= '0;
        end else begin
            r_tag <= w_tag_nxt;
            if (w_start_acc) begin
                r_lfsr      <= w_seed;
                r_stim      <= f_stim(w_seed);
                r_tc        <= bus.test_count;
                r_issue_idx <= '0;
                r_check_idx <= '0;
                r_pass      <= '0;
                r_fail      <= '0;
                r_ff_vld    <= 1'b0;
                r_ff_idx    <= '0;
            end else begin
                if (w_adv) begin
                    r_lfsr      <= w_lfsr_nxt;
                    r_stim      <= f_stim(w_lfsr_nxt);
                    r_issue_idx <= r_issue_idx + CNT_W'(1);
                end
                if (w_sample) begin
                    r_check_idx <= f_sat_inc(r_check_idx);
                    if (w_mis) r_fail <= f_sat_inc(r_fail);
                    else       r_pass <= f_sat_inc(r_pass);
                    if (w_mis && !r_ff_vld) begin
                        r_ff_vld <= 1'b1;
                        r_ff_idx <= r_check_idx;
                    end
                end
            end
        end
    end

    assign bus.stim_o           = r_stim;
    assign bus.busy             = w_busy;
    assign bus.done             = w_done;
    assign bus.pass_count       = r_pass;
    assign bus.fail_count       = r_fail;
    assign bus.first_fail_valid = r_ff_vld;
    assign bus.first_fail_idx   = r_ff_idx;
endmodule

// File: tb/tb_bit_accuracy_sequencer.sv
// Purpose : self-checking bench for bit_accuracy_sequencer with a registered (LAT=1) stand-in circuit.
// Ports   : none; instantiates the interface and the sequencer.
// Scheme  : expected stimulus vectors queued at start, popped and compared as each RUN cycle presents one.
module tb_bit_accuracy_sequencer;
    localparam int IN_W  = 1894;
    localparam int LAT   = 1;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_vec  = -1;   // index of the vector on stim_o this cycle, -1 if none
    int   fail_vec = -1;   // vector whose circuit output is corrupted

    logic [IN_W-1:0] sb_q[$];

    always #5 clk = ~clk;

    bit_accuracy_sequencer_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();

    bit_accuracy_sequencer #(.IN_W(IN_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in circuit: one register stage, golden bit is the parity of the stimulus.
    always @(posedge clk) begin
        bus.ref_o <= ^bus.stim_o;
        bus.dut_o <= (^bus.stim_o) ^ (cur_vec >= 0 && cur_vec == fail_vec);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] m_next(input logic [63:0] l);
        return l[0] ? ((l >> 1) ^ 64'hD800_0000_0000_0000) : (l >> 1);
    endfunction

    function automatic logic [IN_W-1:0] m_stim(input logic [63:0] l);
        logic [IN_W-1:0] v;
        logic [63:0]     c;
        int              r;
        v = '0;
        for (int j = 0; j * 64 < IN_W; j++) begin
            r = j % 64;
            c = (r == 0) ? l : ((l << r) | (l >> (64 - r)));
            for (int b = 0; b < 64; b++)
                if (j * 64 + b < IN_W) v[j * 64 + b] = c[b];
        end
        return v;
    endfunction

    task automatic run_test(input int n, input logic [63:0] sd, input int fv, input bit poke);
        logic [63:0]     l;
        logic [IN_W-1:0] exp_v, last_v;
        int              cyc, waited, exp_fail;
        l = (sd == 64'h0) ? 64'h1 : sd;
        sb_q.delete();
        for (int k = 0; k < n; k++) begin
            sb_q.push_back(m_stim(l));
            l = m_next(l);
        end
        fail_vec = fv;
        last_v   = m_stim((sd == 64'h0) ? 64'h1 : sd);
        bus.start      = 1'b1;
        bus.test_count = CNT_W'(n);
        bus.seed       = sd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("load_busy", 64'(bus.busy), 64'd1);
        chk("load_stim_diffbits", 64'($countones(bus.stim_o ^ last_v)), 64'd0);
        chk("load_cleared", 64'(bus.pass_count + bus.fail_count), 64'd0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            cur_vec   = k;
            bus.start = poke && (k == 10);
            if (poke && k == 10) bus.test_count = CNT_W'(5);
            if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                exp_v  = sb_q.pop_front();
                last_v = exp_v;
                chk($sformatf("stim_v%0d_diffbits", k), 64'($countones(bus.stim_o ^ exp_v)), 64'd0);
            end
        end
        bus.start = 1'b0;
        cyc    = n;
        waited = 0;
        while (!bus.done && waited < 20) begin
            @(posedge clk); #1;
            cur_vec = -1;
            cyc++;
            waited++;
        end
        exp_fail = (fv >= 0 && fv < n) ? 1 : 0;
        chk("done", 64'(bus.done), 64'd1);
        chk("done_cycles", 64'(cyc), (n == 0) ? 64'd1 : 64'(n + 2));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("pass_count", 64'(bus.pass_count), 64'(n - exp_fail));
        chk("fail_count", 64'(bus.fail_count), 64'(exp_fail));
        chk("first_fail_valid", 64'(bus.first_fail_valid), 64'(exp_fail));
        chk("first_fail_idx", 64'(bus.first_fail_idx), exp_fail ? 64'(fv) : 64'd0);
        chk("stim_hold_diffbits", 64'($countones(bus.stim_o ^ last_v)), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", 64'(bus.done), 64'd1);
        chk("pass_frozen", 64'(bus.pass_count), 64'(n - exp_fail));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_pass"}, 64'(bus.pass_count), 64'd0);
        chk({tag, "_fail"}, 64'(bus.fail_count), 64'd0);
        chk({tag, "_ffv"}, 64'(bus.first_fail_valid), 64'd0);
        chk({tag, "_ffi"}, 64'(bus.first_fail_idx), 64'd0);
        chk({tag, "_stim_ones"}, 64'($countones(bus.stim_o)), 64'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.test_count = '0;
        bus.seed       = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_test(1000, 64'h1, -1, 1'b0);                   // clean run
        run_test(100, 64'hDEAD_BEEF_CAFE_F00D, 37, 1'b1);  // one bad vector, start poked mid-run
        run_test(0, 64'h1234_5678_9ABC_DEF0, -1, 1'b0);    // empty run
        run_test(20, 64'h0, -1, 1'b0);                     // zero seed behaves like seed 1

        // Reset in the middle of a run discards everything.
        bus.start      = 1'b1;
        bus.test_count = CNT_W'(100);
        bus.seed       = 64'h5555_0000_AAAA_1111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (51) @(posedge clk);
        #1;
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("midrun_rst");
        run_test(10, 64'h0F0F_0F0F_0F0F_0F0F, -1, 1'b0);

        // Reset and start together: reset wins.
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.test_count = CNT_W'(4);
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        chk_reset_state("rst_vs_start");
        @(posedge clk); #1;
        chk("rst_vs_start_idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
